// File: rtl/pc_gen_if.sv
// Fetch-side bus between the PC generator and instruction memory.
//   o_pc       fetch address (driven by the PC generator)
//   o_ce       instruction memory chip enable
//   o_req      fetch request, always equal to o_ce
//   o_misalign o_pc is not a multiple of the instruction size
//   i_gnt      memory accepts the current o_pc this cycle
// Modports: master = PC generator, slave = instruction memory side.
interface pc_gen_if #(
  parameter int N_ADDR = 32
);
  logic [N_ADDR-1:0] o_pc;
  logic              o_ce;
  logic              o_req;
  logic              o_misalign;
  logic              i_gnt;

  modport master (output o_pc, output o_ce, output o_req, output o_misalign,
                  input  i_gnt);
  modport slave  (input  o_pc, input  o_ce, input  o_req, input  o_misalign,
                  output i_gnt);
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator at the head of the fetch pipeline.
// Produces the fetch address and chip enable for instruction memory, with a
// req/gnt handshake, a highest-priority flush redirect and a one-entry
// buffer that holds a branch redirect arriving while the PC cannot advance.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_stall        pipeline stall vector; only bit 0 (PC stage) is used
//   i_flush        flush/exception redirect request
//   i_flush_addr   flush target
//   i_branch_vld   branch/jump redirect pulse from decode
//   i_branch_addr  branch target
//   o_pend_vld     a branch redirect is buffered and not yet applied
//   fetch          fetch bus (o_pc, o_ce, o_req, o_misalign, i_gnt)
module pc_gen #(
  parameter int                N_ADDR       = 32,
  parameter logic [N_ADDR-1:0] RESET_VECTOR = '0,
  parameter int                INST_BYTES   = 4,
  parameter int                STALL_W      = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [STALL_W-1:0] i_stall,
  input  logic               i_flush,
  input  logic [N_ADDR-1:0]  i_flush_addr,
  input  logic               i_branch_vld,
  input  logic [N_ADDR-1:0]  i_branch_addr,
  output logic               o_pend_vld,
  pc_gen_if.master           fetch
);

  localparam int                OFF_W  = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
  localparam logic [N_ADDR-1:0] PC_INC = N_ADDR'(INST_BYTES);

  logic [N_ADDR-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic              pend_vld_q, pend_vld_d;
  logic [N_ADDR-1:0] pend_addr_q, pend_addr_d;
  logic              adv;

  // The PC moves only when memory takes the current address and the PC
  // stage is not stalled.
  assign adv = ce_q & fetch.i_gnt & ~i_stall[0];

  always_comb begin
    // NOTE: every signal gets a default before the if-chain so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    pc_d        = pc_q;
    ce_d        = 1'b1;     // chip enable rises on the first edge after reset
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;

    // Redirects are ignored until the fetch unit is enabled, which keeps
    // o_pc at RESET_VECTOR through the first post-reset edge.
    if (ce_q) begin
      if (i_flush) begin
        // Flush wins over everything, even without a grant; a same-cycle
        // branch and any buffered branch are dropped.
        pc_d       = i_flush_addr;
        pend_vld_d = 1'b0;
      end else if (adv && i_branch_vld) begin
        // A fresh branch supersedes an older buffered one.
        pc_d       = i_branch_addr;
        pend_vld_d = 1'b0;
      end else if (adv && pend_vld_q) begin
        pc_d       = pend_addr_q;
        pend_vld_d = 1'b0;
      end else if (adv) begin
        pc_d = pc_q + PC_INC;   // wraps modulo 2^N_ADDR
      end else if (i_branch_vld) begin
        // PC cannot move: park the branch so it is not lost.
        pend_addr_d = i_branch_addr;
        pend_vld_d  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q        <= RESET_VECTOR;
      ce_q        <= 1'b0;
      pend_vld_q  <= 1'b0;
      // NOTE: the buffered address is only meaningful when pend_vld_q is set,
      // but it is reset too so no X ever reaches o_pc.
      pend_addr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ce_q        <= ce_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign fetch.o_pc  = pc_q;
  assign fetch.o_ce  = ce_q;
  assign fetch.o_req = ce_q;
  assign o_pend_vld  = pend_vld_q;

  // Targets are loaded unmodified; misalignment is flagged, never corrected.
  if (INST_BYTES > 1) begin : g_misalign
    assign fetch.o_misalign = |pc_q[OFF_W-1:0];
  end else begin : g_no_misalign
    assign fetch.o_misalign = 1'b0;
  end

  // Stall bits for later pipeline stages are not used by this block.
  if (STALL_W > 1) begin : g_stall_hi
    logic unused_stall_hi;
    assign unused_stall_hi = |i_stall[STALL_W-1:1];
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen. Two instances share one stimulus stream:
//   dut_a: N_ADDR=32, RESET_VECTOR=BFC0_0000
//   dut_b: N_ADDR=8,  RESET_VECTOR=F0 (sees the low byte of every target)
// A directed table exercises the listed scenarios, then randomized traffic
// is checked every cycle against a behavioural model of the PC rules.
module tb_pc_gen;

  localparam logic [31:0] RV_A = 32'hBFC0_0000;
  localparam logic [7:0]  RV_B = 8'hF0;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stall;
  logic        gnt;
  logic        flush;
  logic [31:0] faddr;
  logic        bvld;
  logic [31:0] baddr;
  logic        pv_a, pv_b;

  int n_vec  = 0;
  int n_miss = 0;

  pc_gen_if #(.N_ADDR(32)) if_a ();
  pc_gen_if #(.N_ADDR(8))  if_b ();
  assign if_a.i_gnt = gnt;
  assign if_b.i_gnt = gnt;

  pc_gen #(.N_ADDR(32), .RESET_VECTOR(RV_A), .INST_BYTES(4), .STALL_W(6)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
    .i_flush(flush), .i_flush_addr(faddr),
    .i_branch_vld(bvld), .i_branch_addr(baddr),
    .o_pend_vld(pv_a), .fetch(if_a));

  pc_gen #(.N_ADDR(8), .RESET_VECTOR(RV_B), .INST_BYTES(4), .STALL_W(6)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
    .i_flush(flush), .i_flush_addr(faddr[7:0]),
    .i_branch_vld(bvld), .i_branch_addr(baddr[7:0]),
    .o_pend_vld(pv_b), .fetch(if_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Index 0 models dut_a, index 1 models dut_b.
  logic [31:0] m_pc [2];
  logic [31:0] m_pa [2];
  bit          m_ce [2];
  bit          m_pv [2];

  task automatic model_reset();
    m_pc[0] = RV_A;  m_pc[1] = {24'h0, RV_B};
    for (int k = 0; k < 2; k++) begin
      m_ce[k] = 0; m_pv[k] = 0; m_pa[k] = '0;
    end
  endtask

  // Apply one clock edge worth of the PC rules to the model.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] msk;
      bit          adv;
      msk = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      adv = gnt && !stall[0];
      if (!m_ce[k]) begin
        m_ce[k] = 1;                       // redirects ignored while disabled
      end else if (flush) begin
        m_pc[k] = faddr & msk;  m_pv[k] = 0;
      end else if (adv && bvld) begin
        m_pc[k] = baddr & msk;  m_pv[k] = 0;
      end else if (adv && m_pv[k]) begin
        m_pc[k] = m_pa[k];      m_pv[k] = 0;
      end else if (adv) begin
        m_pc[k] = (m_pc[k] + 4) & msk;
      end else if (bvld) begin
        m_pa[k] = baddr & msk;  m_pv[k] = 1;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_all();
    check("a_pc",  if_a.o_pc, m_pc[0]);
    check("a_ce",  32'(if_a.o_ce),  32'(m_ce[0]));
    check("a_req", 32'(if_a.o_req), 32'(m_ce[0]));
    check("a_pv",  32'(pv_a),       32'(m_pv[0]));
    check("a_mis", 32'(if_a.o_misalign), 32'(m_pc[0][1:0] != 2'b00));
    check("b_pc",  32'(if_b.o_pc), m_pc[1]);
    check("b_ce",  32'(if_b.o_ce),  32'(m_ce[1]));
    check("b_req", 32'(if_b.o_req), 32'(m_ce[1]));
    check("b_pv",  32'(pv_b),       32'(m_pv[1]));
    check("b_mis", 32'(if_b.o_misalign), 32'(m_pc[1][1:0] != 2'b00));
  endtask

  // Inputs are set before calling; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle_inputs();
    stall = '0; gnt = 1'b1; flush = 1'b0; faddr = '0; bvld = 1'b0; baddr = '0;
  endtask

  // Reset asserted between edges, held across one edge, then released.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp_all();
    @(posedge clk);
    #1;
    cmp_all();
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [5:0]  stall;
    logic        gnt;
    logic        flush;
    logic [31:0] faddr;
    logic        bvld;
    logic [31:0] baddr;
    logic [31:0] e_pc;
    logic        e_pv;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [5:0] st, logic g, logic fl, logic [31:0] fa,
                              logic bv, logic [31:0] ba,
                              logic [31:0] epc, logic epv, logic emis);
    vec_t v;
    v.stall = st; v.gnt = g; v.flush = fl; v.faddr = fa;
    v.bvld = bv; v.baddr = ba; v.e_pc = epc; v.e_pv = epv; v.e_mis = emis;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    if ($urandom_range(0, 7) == 0) a[31:4] = '1;   // near the wrap point
    return a;
  endfunction

  initial begin
    // Free run from reset, then the listed scenarios, expected for dut_a.
    tbl.push_back(mk(6'h00, 1, 0, 0, 0, 0,            32'hBFC0_0004, 0, 0));
    tbl.push_back(mk(6'h00, 1, 0, 0, 0, 0,            32'hBFC0_0008, 0, 0));
    tbl.push_back(mk(6'h00, 1, 0, 0, 1, 32'h100,      32'h100, 0, 0));
    // branch during a 3-cycle stall
    tbl.push_back(mk(6'h01, 1, 0, 0, 1, 32'h200,      32'h100, 1, 0));
    tbl.push_back(mk(6'h01, 1, 0, 0, 0, 0,            32'h100, 1, 0));
    tbl.push_back(mk(6'h01, 1, 0, 0, 0, 0,            32'h100, 1, 0));
    tbl.push_back(mk(6'h00, 1, 0, 0, 0, 0,            32'h200, 0, 0));
    tbl.push_back(mk(6'h00, 1, 0, 0, 0, 0,            32'h204, 0, 0));
    // flush beats pending and same-cycle branch, without grant
    tbl.push_back(mk(6'h01, 0, 0, 0, 1, 32'h300,      32'h204, 1, 0));
    tbl.push_back(mk(6'h01, 0, 1, 32'h380, 1, 32'h400, 32'h380, 0, 0));
    tbl.push_back(mk(6'h01, 0, 0, 0, 0, 0,            32'h380, 0, 0));
    // handshake hold at 0x40
    tbl.push_back(mk(6'h00, 1, 0, 0, 1, 32'h40,       32'h40, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(6'h00, 0, 0, 0, 0, 0,          32'h40, 0, 0));
    tbl.push_back(mk(6'h00, 1, 0, 0, 0, 0,            32'h44, 0, 0));
    // misaligned target is loaded and incremented as-is
    tbl.push_back(mk(6'h00, 1, 0, 0, 1, 32'h42,       32'h42, 0, 1));
    tbl.push_back(mk(6'h00, 1, 0, 0, 0, 0,            32'h46, 0, 1));
    // newer pending overwrites older; new branch supersedes pending
    tbl.push_back(mk(6'h00, 0, 0, 0, 1, 32'h500,      32'h46, 1, 1));
    tbl.push_back(mk(6'h00, 0, 0, 0, 1, 32'h600,      32'h46, 1, 1));
    tbl.push_back(mk(6'h00, 1, 0, 0, 0, 0,            32'h600, 0, 0));
    tbl.push_back(mk(6'h00, 0, 0, 0, 1, 32'h700,      32'h600, 1, 0));
    tbl.push_back(mk(6'h00, 1, 0, 0, 1, 32'h800,      32'h800, 0, 0));
    // upper stall bits do not freeze the PC
    tbl.push_back(mk(6'h3E, 1, 0, 0, 0, 0,            32'h804, 0, 0));
    // wrap (dut_b wraps FC -> 00 on the same vectors)
    tbl.push_back(mk(6'h00, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0));
    tbl.push_back(mk(6'h00, 1, 0, 0, 0, 0,            32'h0, 0, 0));

    // ---- reset state ----
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    cmp_all();
    check("rst_pc",  if_a.o_pc, RV_A);
    check("rst_ce",  32'(if_a.o_ce), 32'd0);
    check("rst_req", 32'(if_a.o_req), 32'd0);
    check("rst_pv",  32'(pv_a), 32'd0);
    #3;
    rst_n = 1'b1;

    // ---- first edge after release: ce rises, redirects ignored ----
    flush = 1'b1; faddr = 32'h1234; bvld = 1'b1; baddr = 32'h5678;
    cycle();
    check("first_pc", if_a.o_pc, RV_A);
    check("first_ce", 32'(if_a.o_ce), 32'd1);
    check("first_pv", 32'(pv_a), 32'd0);
    idle_inputs();

    // ---- table ----
    for (int i = 0; i < tbl.size(); i++) begin
      stall = tbl[i].stall; gnt = tbl[i].gnt; flush = tbl[i].flush;
      faddr = tbl[i].faddr; bvld = tbl[i].bvld; baddr = tbl[i].baddr;
      cycle();
      check($sformatf("t%0d_pc", i),  if_a.o_pc, tbl[i].e_pc);
      check($sformatf("t%0d_ce", i),  32'(if_a.o_req), 32'd1);
      check($sformatf("t%0d_pv", i),  32'(pv_a), 32'(tbl[i].e_pv));
      check($sformatf("t%0d_mis", i), 32'(if_a.o_misalign), 32'(tbl[i].e_mis));
    end
    check("wrap_b_pc", 32'(if_b.o_pc), 32'h0);
    idle_inputs();

    // ---- mid-run reset discards a pending redirect ----
    gnt = 1'b0; bvld = 1'b1; baddr = 32'h900;
    cycle();
    check("pre_rst_pv", 32'(pv_a), 32'd1);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_pc", if_a.o_pc, RV_A);
    check("mid_rst_ce", 32'(if_a.o_ce), 32'd0);
    check("mid_rst_pv", 32'(pv_a), 32'd0);
    cmp_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 600; n++) begin
      stall    = 6'($urandom);
      stall[0] = ($urandom_range(0, 3) == 0);
      gnt      = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      faddr    = rand_addr();
      bvld     = ($urandom_range(0, 5) == 0);
      baddr    = rand_addr();
      if ($urandom_range(0, 99) == 0) mid_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter generator at the head of the fetch pipeline.
- Produces the fetch address and chip-enable for instruction memory.
- Adds the following over the previous generation:
  - configurable address width, reset vector and instruction size;
  - a req/gnt fetch handshake;
  - a highest-priority flush (exception) redirect;
  - a one-entry pending-redirect buffer, so branches that resolve while the PC cannot advance are not lost.

Parameters:
N_ADDR, 32, PC / fetch address width in bits
RESET_VECTOR, 32'h0000_0000, PC value held in and after reset until the first accepted fetch
INST_BYTES, 4, PC increment per fetch; power of two, >=1
STALL_W, 6, width of pipeline stall vector; bit 0 is the PC stage

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_stall  input  STALL_W  stall vector; i_stall[0]==1 freezes the PC
i_gnt  input  1  instruction memory accepts the current o_pc this cycle
i_flush  input  1  exception/flush redirect request
i_flush_addr  input  N_ADDR  flush target
i_branch_vld  input  1  branch/jump redirect from decode, single-cycle pulse
i_branch_addr  input  N_ADDR  branch target
o_pc  output  N_ADDR  current fetch address
o_ce  output  1  instruction memory chip enable
o_req  output  1  fetch request; equals o_ce
o_pend_vld  output  1  a branch redirect is buffered and not yet applied
o_misalign  output  1  combinational; 1 when o_pc[log2(INST_BYTES)-1:0] != 0 (tied 0 when INST_BYTES==1)

Behaviour:
- Reset (async, i_rst_n==0): o_ce=0, o_pc=RESET_VECTOR, pending buffer cleared (o_pend_vld=0), o_req=0.
- o_ce rises on the first rising edge after reset release. While o_ce==0:
  - o_pc holds RESET_VECTOR;
  - flush and branch inputs are ignored and are not buffered.
- Define adv = o_ce & i_gnt & ~i_stall[0]. The PC advances only when adv==1.
- Next-state priority, evaluated each edge with o_ce==1:
  1. i_flush: o_pc<=i_flush_addr and pending cleared, regardless of stall or gnt. A same-cycle branch is discarded.
  2. adv & i_branch_vld: o_pc<=i_branch_addr; pending cleared. A new branch supersedes an older pending one.
  3. adv & o_pend_vld: o_pc<=pending addr; pending cleared.
  4. adv: o_pc<=o_pc+INST_BYTES, modulo 2^N_ADDR (wraps from all-ones region to 0; no overflow flag).
  5. ~adv & i_branch_vld: o_pc holds; pending<=i_branch_addr, o_pend_vld<=1. Overwrites any older pending entry.
  6. otherwise: o_pc holds; pending holds.
- Latency:
  - redirect to o_pc is one cycle after the input edge;
  - a buffered redirect appears one cycle after the first adv cycle.
- o_pc and o_req are stable while o_req==1 and i_gnt==0, except on flush, which may change o_pc without a grant.
- Target addresses are loaded unmodified; misalignment is only flagged via o_misalign, never corrected.
- Upper bits of i_stall (bits STALL_W-1..1) are ignored by this block.
- Reset asserted mid-operation returns all state to reset values immediately, including discarding a pending redirect.

Test Plan:
- Reset then free-run with i_gnt=1, no stall, RESET_VECTOR=32'hBFC0_0000:
  - o_ce=0 at the first edge after release, then 1;
  - o_pc sequence BFC00000, BFC00000, BFC00004, BFC00008.
- Branch during stall, INST_BYTES=4:
  - o_pc=0x100; assert i_stall[0]=1 for 3 cycles with a single-cycle i_branch_vld=1 to 0x200 in the first of them.
  - Required: o_pend_vld=1 during the stall, o_pc stays 0x100.
  - After the stall drops, o_pc=0x200 next cycle, o_pend_vld=0, then 0x204.
- Flush priority:
  - i_gnt=0, i_stall[0]=1, o_pend_vld=1 (0x300).
  - Assert i_flush with 0x380 and i_branch_vld with 0x400 in the same cycle.
  - Required: o_pc=0x380 next cycle, o_pend_vld=0.
- Handshake hold: i_gnt=0 for 4 cycles at o_pc=0x40 -> o_pc stays 0x40 and o_req stays 1; grant returns -> 0x44.
- Wrap and misalign, N_ADDR=8, INST_BYTES=4:
  - o_pc=0xFC with adv -> o_pc=0x00.
  - Branch to 0x42 -> o_pc=0x42 with o_misalign=1, then 0x46 with o_misalign=1.
- Mid-run reset: assert i_rst_n=0 asynchronously between edges while o_pend_vld=1 -> o_pc=RESET_VECTOR, o_ce=0, o_pend_vld=0 immediately.
